uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART receiver; the receive-direction counterpart of the team's uart_tx in toptop.
//   - Samples asynchronous serial line uart_rxd: 8N1-style framing with PAYLOAD_BITS data bits.
//   - Frame = 1 start, data bits LSB first, optional parity, 1 stop.
//   - Presents each received word with a one-cycle valid pulse; flags framing, break and parity errors.
// PARAMETERS
//   CLK_HZ        50_000_000  system clock frequency in Hz
//   BIT_RATE      115_200     serial bit rate in bit/s; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide, >= 4)
//   PAYLOAD_BITS  4           data bits per frame
// PORTS
//   clk               in   1             system clock, rising edge
//   reset             in   1             asynchronous reset, active-high
//   uart_rxd          in   1             serial input, idle high, asynchronous to clk
//   uart_rx_en        in   1             1 = new start bits are accepted
//   uart_rx_valid     out  1             one-cycle pulse: uart_rx_data holds a good word
//   uart_rx_data      out  PAYLOAD_BITS  last received word
//   uart_rx_frame_err out  1             one-cycle pulse: stop bit sampled low
//   uart_rx_break     out  1             one-cycle pulse: frame error with all data bits 0
//   uart_rx_parity_err out 1             only when UART_RX_PARITY_EN is defined
// BEHAVIOUR
//   - Reset: all outputs 0, uart_rx_data 0, FSM IDLE, synchroniser flops 1.
//     Asynchronous abort of any frame in progress; no pulse is emitted for the aborted frame.
//   - uart_rxd passes through a 2-flop synchroniser; all logic uses the synced value rxs.
//   - Bit counter: counts 0..CYCLES_PER_BIT-1, wraps to 0. Mid-bit sample point = CYCLES_PER_BIT/2.
//   - FSM states:
//     IDLE:   rxs==0 && uart_rx_en -> START; counter cleared.
//     START:  at half-bit, resample rxs.
//             - rxs==1: false start -> IDLE (no outputs).
//             - rxs==0: -> DATA, counter restarted.
//     DATA:   each full CYCLES_PER_BIT, shift rxs into the shift register LSB-first.
//             After PAYLOAD_BITS samples -> PARITY (feature on) or STOP.
//     PARITY: one bit period; sample the parity bit, then -> STOP.
//     STOP:   sample rxs at the stop-bit mid-point.
//             - rxs==1: uart_rx_data <= shift reg; uart_rx_valid=1 for 1 cycle; -> IDLE.
//             - rxs==0: uart_rx_frame_err=1 for 1 cycle; uart_rx_break=1 in the same cycle
//               if all data bits are 0; uart_rx_data unchanged; -> WAIT_HI.
//     WAIT_HI: stay until rxs==1, then -> IDLE. Prevents a held-low line re-triggering.
//   - Latency: valid asserts 2 (sync) + 1 cycles after the stop-bit mid-sample.
//     That is about (1.5 + PAYLOAD_BITS [+1]) bit times after the start falling edge.
//   - Back-to-back frames: IDLE is re-entered at the stop mid-point.
//     A start edge arriving half a stop bit later is accepted.
//   - uart_rx_en deassert mid-frame: the frame completes normally; en gates only IDLE->START.
//   - uart_rx_data holds its value between frames. valid, frame_err and break are never
//     high for more than 1 cycle.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - Frame carries an even-parity bit after the data bits; PARITY state is present.
//     - uart_rx_parity_err pulses together with uart_rx_valid when XOR(data, parity bit) != 0.
//     - On a parity error the word is still delivered.
//   UART_RX_PARITY_EN undefined:
//     - No parity bit, no PARITY state; the uart_rx_parity_err port is absent.
// TESTING  (bench uses CLK_HZ=1_000_000, BIT_RATE=100_000 -> 10 cycles/bit)
//   1. Idle line, send 4'hA (start, 0,1,0,1, stop)
//      -> single uart_rx_valid pulse; uart_rx_data=4'hA; frame_err=0, break=0.
//   2. Back-to-back 4'h3 then 4'hC, one stop bit each
//      -> two valid pulses 60 cycles apart; data 4'h3 then 4'hC.
//   3. Low glitch of 3 cycles on idle line
//      -> no valid/frame_err; FSM back in IDLE; following frame 4'h9 received correctly.
//   4. Frame 4'h5 with stop bit 0 -> frame_err pulse, no valid, data unchanged.
//      Line held low for 80 cycles -> frame_err+break pulse once, no further pulses until line high.
//   5. reset asserted during data bit 2 -> all outputs 0 asynchronously.
//      Release, send 4'h6 -> valid with data=4'h6.
//   6. With UART_RX_PARITY_EN, send 4'h7 with parity bit 0 (wrong)
//      -> valid=1, parity_err=1, data=4'h7.
//      Same frame with parity bit 1 -> valid=1, parity_err=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: UART receiver for start / PAYLOAD_BITS data (LSB first) / [parity] / stop frames.
// The serial input is brought into the clk domain by a two-flop synchroniser.
// A single FSM tracks the frame and presents each word with one-cycle result pulses.
// A frame whose stop bit is sampled low raises a frame-error pulse.
// If all its data bits were also zero, a break pulse is raised in the same cycle.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit after the data bits.
// That build adds the uart_rx_parity_err output.
module uart_rx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 115_200,
    parameter int PAYLOAD_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                    uart_rx_parity_err,
`endif
    output logic                    uart_rx_break
);

    // Bit timing. CYCLES_PER_BIT must be at least 4 so that the half-bit point is distinct.
    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam int IDX_W          = $clog2(PAYLOAD_BITS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY  = 3'd5
`endif
    } state_t;

    // Synchroniser flops; both idle high so that reset never looks like a start edge.
    logic rxd_meta_q;
    logic rxs_q;

    // Frame tracking state
    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    bit_end;
    logic [IDX_W-1:0]        bit_idx_q;
    logic [PAYLOAD_BITS-1:0] shift_q;
    logic [PAYLOAD_BITS-1:0] shift_d;
    logic [PAYLOAD_BITS:0]   shift_wide;

    // Registered outputs
    logic                    valid_q;
    logic                    frame_err_q;
    logic                    break_q;
    logic [PAYLOAD_BITS-1:0] data_q;
`ifdef UART_RX_PARITY_EN
    logic                    parity_bit_q;
    logic                    parity_err_q;
`endif

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxs_q      <= rxd_meta_q;
        end
    end

    // Bit counter wrap and LSB-first shift (new bit enters at the MSB, ends at the LSB)
    always_comb begin
        bit_end    = (cnt_q == CNT_W'(CYCLES_PER_BIT - 1));
        cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
        shift_wide = {rxs_q, shift_q};
        shift_d    = shift_wide[PAYLOAD_BITS:1];
    end

    // Receive FSM with registered result pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            break_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Result outputs are pulses: they only live for the cycle after they are set.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    // The enable only gates new frames; a frame already running always completes.
                    if (!rxs_q && uart_rx_en) begin
                        state_q <= START;
                    end
                end

                START: begin
                    // Re-check the line at half a bit; a high line means it was only a glitch.
                    if (cnt_q == CNT_W'(HALF_BIT)) begin
                        cnt_q   <= '0;
                        state_q <= rxs_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    // Whole-bit steps from the start mid-point land on each data bit's mid-point.
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == IDX_W'(PAYLOAD_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        parity_bit_q <= rxs_q;
                        state_q      <= STOP;
                    end
                end
`endif

                STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (rxs_q) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            // Even parity: data bits plus parity bit must XOR to zero.
                            parity_err_q <= (^shift_q) ^ parity_bit_q;
`endif
                            // Returning at the stop mid-point lets a back-to-back start be caught.
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            break_q     <= (shift_q == '0);
                            state_q     <= WAIT_HI;
                        end
                    end
                end

                WAIT_HI: begin
                    // A line held low (break) must not be re-read as a stream of new frames.
                    cnt_q <= '0;
                    if (rxs_q) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign uart_rx_valid     = valid_q;
    assign uart_rx_data      = data_q;
    assign uart_rx_frame_err = frame_err_q;
    assign uart_rx_break     = break_q;
`ifdef UART_RX_PARITY_EN
    assign uart_rx_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames plus a randomized frame stream.
// Results are checked against an expected-event list built from the frame format.
module tb_uart_rx;

    localparam int CPB = 10;
    localparam int N   = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NPAR  = PAR_EN ? 1 : 0;
    localparam int FRAME = (2 + N + NPAR) * CPB;
    // Line-time offset of the stop-bit mid-point from the start edge
    localparam int STOP_MID = (1 + N + NPAR) * CPB + CPB / 2;
    // Synchroniser plus output register plus sampling slack
    localparam int SLACK = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         uart_rxd;
    logic         uart_rx_en;
    logic         uart_rx_valid;
    logic [N-1:0] uart_rx_data;
    logic         uart_rx_frame_err;
    logic         uart_rx_break;
    logic         perr_w;

    uart_rx #(
        .CLK_HZ       (1_000_000),
        .BIT_RATE     (100_000),
        .PAYLOAD_BITS (N)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_frame_err (uart_rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .uart_rx_parity_err(perr_w),
`endif
        .uart_rx_break     (uart_rx_break)
    );

`ifndef UART_RX_PARITY_EN
    assign perr_w = 1'b0;
`endif

    always #5 clk = ~clk;

    // kind: bit1 = valid, bit0 = frame_err
    typedef struct {
        int           kind;
        logic [N-1:0] data;
        logic         brk;
        logic         perr;
        int           lo;
        int           hi;
    } ev_t;

    ev_t          exp_q[$];
    ev_t          obs_q[$];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;
    int           multi = 0;
    logic [N-1:0] last_data = '0;
    logic         prev_v = 1'b0;
    logic         prev_fe = 1'b0;
    logic         prev_brk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle that shows any result output, plus pulses longer than one cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (uart_rx_valid || uart_rx_frame_err || uart_rx_break || perr_w) begin
                ev_t o;
                o.kind = int'({uart_rx_valid, uart_rx_frame_err});
                o.data = uart_rx_data;
                o.brk  = uart_rx_break;
                o.perr = perr_w;
                o.lo   = cyc;
                o.hi   = cyc;
                obs_q.push_back(o);
            end
            if ((uart_rx_valid && prev_v) || (uart_rx_frame_err && prev_fe) || (uart_rx_break && prev_brk))
                multi++;
        end
        prev_v   = uart_rx_valid;
        prev_fe  = uart_rx_frame_err;
        prev_brk = uart_rx_break;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_tests++;
        if (got !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expected);
        end
    endtask

    task automatic line_for(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // Expected outcome of a frame starting at line cycle t0
    task automatic expect_frame(input int t0, input logic [N-1:0] d, input logic sb, input logic pb);
        ev_t e;
        e.lo = t0 + STOP_MID;
        e.hi = t0 + STOP_MID + SLACK;
        if (sb) begin
            e.kind    = 2;
            e.data    = d;
            e.brk     = 1'b0;
            e.perr    = PAR_EN ? ((^d) ^ pb) : 1'b0;
            last_data = d;
        end else begin
            e.kind = 1;
            e.data = last_data;
            e.brk  = (d == '0);
            e.perr = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // mode 0: enable held; mode 1: enable dropped after the start bit; mode 2: enable low throughout
    task automatic send_frame(input logic [N-1:0] d, input logic sb, input logic pb, input int mode);
        int t0;
        t0 = cyc;
        if (mode == 2) uart_rx_en = 1'b0;
        else expect_frame(t0, d, sb, pb);
        line_for(1'b0, CPB);
        if (mode == 1) uart_rx_en = 1'b0;
        for (int i = 0; i < N; i++) line_for(d[i], CPB);
        if (PAR_EN) line_for(pb, CPB);
        line_for(sb, CPB);
        uart_rx_en = 1'b1;
    endtask

    task automatic compare_events(input string tag);
        ev_t e;
        ev_t o;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_kind"}, o.kind, e.kind);
            check({tag, "_data"}, 32'(o.data), 32'(e.data));
            check({tag, "_brk"}, 32'(o.brk), 32'(e.brk));
            check({tag, "_perr"}, 32'(o.perr), 32'(e.perr));
            check({tag, "_time"}, 32'(o.lo >= e.lo && o.lo <= e.hi), 32'd1);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    function automatic logic good_par(input logic [N-1:0] d);
        return ^d;
    endfunction

    initial begin
        reset      = 1'b1;
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(uart_rx_valid), 0);
        check("rst_data", 32'(uart_rx_data), 0);
        check("rst_frame_err", 32'(uart_rx_frame_err), 0);
        check("rst_break", 32'(uart_rx_break), 0);
        check("rst_perr", 32'(perr_w), 0);
        reset = 1'b0;
        line_for(1'b1, 10);

        // 1: single frame
        send_frame(4'hA, 1'b1, good_par(4'hA), 0);
        line_for(1'b1, 20);
        compare_events("t1");

        // 2: back-to-back frames, exactly one frame length apart
        send_frame(4'h3, 1'b1, good_par(4'h3), 0);
        send_frame(4'hC, 1'b1, good_par(4'hC), 0);
        line_for(1'b1, 20);
        if (obs_q.size() >= 2) check("t2_gap", obs_q[1].lo - obs_q[0].lo, FRAME);
        else check("t2_gap_events", obs_q.size(), 2);
        compare_events("t2");

        // 3: short low glitch is rejected, next frame is fine
        line_for(1'b0, 3);
        line_for(1'b1, 30);
        compare_events("t3_glitch");
        send_frame(4'h9, 1'b1, good_par(4'h9), 0);
        line_for(1'b1, 20);
        compare_events("t3");

        // 4: bad stop bit, then a long break
        send_frame(4'h5, 1'b0, good_par(4'h5), 0);
        line_for(1'b1, 20);
        expect_frame(cyc, '0, 1'b0, 1'b0);
        line_for(1'b0, 80);
        line_for(1'b1, 30);
        compare_events("t4");
        check("t4_data_hold", 32'(uart_rx_data), 32'(last_data));

        // 5: asynchronous reset during data bit 2 aborts the frame
        check("t5_pre_data", 32'(uart_rx_data), 32'(last_data));
        line_for(1'b0, CPB);
        line_for(1'b0, CPB);
        line_for(1'b1, CPB);
        line_for(1'b1, CPB / 2);
        #2 reset = 1'b1;
        #1;
        check("t5_async_data", 32'(uart_rx_data), 0);
        check("t5_async_valid", 32'(uart_rx_valid), 0);
        check("t5_async_fe", 32'(uart_rx_frame_err), 0);
        uart_rxd = 1'b1;
        last_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        line_for(1'b1, 80);
        compare_events("t5_abort");
        send_frame(4'h6, 1'b1, good_par(4'h6), 0);
        line_for(1'b1, 20);
        compare_events("t5");

`ifdef UART_RX_PARITY_EN
        // 6: parity error still delivers the word
        send_frame(4'h7, 1'b1, 1'b0, 0);
        line_for(1'b1, 20);
        compare_events("t6_bad");
        send_frame(4'h7, 1'b1, 1'b1, 0);
        line_for(1'b1, 20);
        compare_events("t6_good");
`endif

        // Randomized frame stream
        for (int k = 0; k < 24; k++) begin
            logic [N-1:0] d;
            logic         sb;
            logic         pb;
            int           mode;
            int           gap;
            d    = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            sb   = ($urandom_range(0, 4) != 0);
            pb   = (^d) ^ ($urandom_range(0, 3) == 0);
            mode = $urandom_range(0, 5);
            mode = (mode < 4) ? 0 : mode - 3;
            if (mode == 2) sb = 1'b1;
            gap  = sb ? $urandom_range(0, 25) : $urandom_range(10, 30);
            send_frame(d, sb, pb, mode);
            line_for(1'b1, gap);
        end
        line_for(1'b1, 40);
        compare_events("rand");
        check("final_data", 32'(uart_rx_data), 32'(last_data));
        check("pulse_width", multi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
